// File: rtl/spi_master_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_master_pkg
//  Description : Shared command encodings, frame sizes and FSM states for
//                the SPI master.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_master_pkg;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    localparam int FRAME_BITS = 10;
    localparam int RX_BITS    = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEL   = 3'd1,
        ST_SHIFT = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RECV  = 3'd4,
        ST_FIN   = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/spi_master_if.sv
`default_nettype none
// ============================================================================
//  Module      : spi_master_if
//  Description : Host handshake plus SPI pins of the SPI master.
//  Revision    : 1.0 - initial release
// ============================================================================
interface spi_master_if;

    logic       start;
    logic [9:0] tx_word;
    logic       busy;
    logic       done;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;

    modport master (
        input  start, tx_word, MISO,
        output busy, done, rd_data, rd_valid, SS_n, MOSI
    );

    modport slave (
        output start, tx_word, MISO,
        input  busy, done, rd_data, rd_valid, SS_n, MOSI
    );

endinterface
`default_nettype wire

// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
//  Module      : spi_master
//  Description : Single-clock SPI master sending 10-bit command frames and
//                capturing one byte from MISO on rd-data frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_master
    import spi_master_pkg::*;
#(
    parameter int READ_WAIT = 2
) (
    input  wire logic    clk,
    input  wire logic    rst,
    spi_master_if.master bus
);

    localparam int c_cnt_max = (READ_WAIT > FRAME_BITS) ? READ_WAIT : FRAME_BITS;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

    localparam logic [c_cnt_w-1:0] c_last_bit  = c_cnt_w'(FRAME_BITS - 1);
    localparam logic [c_cnt_w-1:0] c_last_wait = c_cnt_w'(READ_WAIT - 1);
    localparam logic [c_cnt_w-1:0] c_last_recv = c_cnt_w'(RX_BITS - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

    state_t                r_state;
    state_t                w_state_next;
    logic [c_cnt_w-1:0]    r_cnt;
    logic [c_cnt_w-1:0]    w_cnt_next;
    logic [FRAME_BITS-1:0] r_word;
    logic [FRAME_BITS-1:0] w_word_next;
    logic [FRAME_BITS-1:0] w_word_shifted;
    logic [RX_BITS-1:0]    r_rx;
    logic [RX_BITS-1:0]    r_rd_data;
    logic                  r_ss_n;
    logic                  r_mosi;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_rd_valid;
    logic                  w_is_rd;
    logic                  w_active;
    logic                  w_mosi_next;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_word_next  = r_word;
        w_is_rd      = (r_word[FRAME_BITS-1 -: 2] == CMD_RD_DATA);

        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_next = ST_SEL;
                    w_cnt_next   = '0;
                    w_word_next  = bus.tx_word;
                end
            end
            ST_SEL: begin
                w_state_next = ST_SHIFT;
                w_cnt_next   = '0;
            end
            ST_SHIFT: begin
                if (r_cnt == c_last_bit) begin
                    w_cnt_next = '0;
                    if (!w_is_rd)
                        w_state_next = ST_FIN;
                    else if (READ_WAIT == 0)
                        w_state_next = ST_RECV;
                    else
                        w_state_next = ST_WAIT;
                end else begin
                    w_cnt_next = r_cnt + c_cnt_one;
                end
            end
            ST_WAIT: begin
                if (r_cnt == c_last_wait) begin
                    w_state_next = ST_RECV;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + c_cnt_one;
                end
            end
            ST_RECV: begin
                if (r_cnt == c_last_recv) begin
                    w_state_next = ST_FIN;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + c_cnt_one;
                end
            end
            ST_FIN:  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase

        w_active = (w_state_next == ST_SEL)  || (w_state_next == ST_SHIFT) ||
                   (w_state_next == ST_WAIT) || (w_state_next == ST_RECV);

        // SEL enters with count 0, so it presents word[9] just like the first SHIFT cycle
        w_word_shifted = w_word_next << w_cnt_next;
        w_mosi_next    = ((w_state_next == ST_SEL) || (w_state_next == ST_SHIFT)) ?
                         w_word_shifted[FRAME_BITS-1] : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_word     <= '0;
            r_rx       <= '0;
            r_rd_data  <= '0;
            r_ss_n     <= 1'b1;
            r_mosi     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rd_valid <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_word     <= w_word_next;
            r_ss_n     <= !w_active;
            r_busy     <= w_active;
            r_mosi     <= w_mosi_next;
            r_done     <= (w_state_next == ST_FIN);
            r_rd_valid <= (w_state_next == ST_FIN) && w_is_rd;
            if (r_state == ST_RECV)
                r_rx <= {r_rx[RX_BITS-2:0], bus.MISO};
            // the eighth bit lands straight in rd_data so it is visible during FIN
            if ((r_state == ST_RECV) && (w_state_next == ST_FIN))
                r_rd_data <= {r_rx[RX_BITS-2:0], bus.MISO};
        end
    end

    assign bus.SS_n     = r_ss_n;
    assign bus.MOSI     = r_mosi;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.rd_valid = r_rd_valid;
    assign bus.rd_data  = r_rd_data;

endmodule
`default_nettype wire
